mul_norm_pipe: RTL and testbench

MUL_NORM_PIPE -- requirements
Module: mul_norm_pipe

---
 rtl/mul_pkg.sv | 27 ++
 rtl/mul_one_detect.sv | 42 ++++
 rtl/mul_norm_pipe.sv | 152 +++++++++++++++
 tb/tb_mul_norm_pipe.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// ---------------------------------------------------------------------------
// mul_pkg
// Shared types for the one-detect / normalise pipeline.
//   mode_e       : scan direction, MODE_LEAD picks the highest set bit,
//                  MODE_TRAIL picks the lowest set bit.
//   mul_result_t : one pipeline payload (mask, idx, zero, norm). Fields are
//                  sized for the widest supported operand (64 bits); narrower
//                  instances zero-extend into them and slice back out.
// ---------------------------------------------------------------------------
package mul_pkg;

  localparam int MAX_W     = 64;
  localparam int MAX_IDX_W = 6;

  typedef enum logic {
    MODE_LEAD  = 1'b0,
    MODE_TRAIL = 1'b1
  } mode_e;

  typedef struct packed {
    logic [MAX_W-1:0]     mask;
    logic [MAX_IDX_W-1:0] idx;
    logic                 zero;
    logic [MAX_W-1:0]     norm;
  } mul_result_t;

endpackage

// File: rtl/mul_one_detect.sv
// ---------------------------------------------------------------------------
// mul_one_detect
// Purely combinational selection of one set bit of an operand.
// Ports:
//   data : operand to scan
//   mode : MODE_LEAD (highest set bit) or MODE_TRAIL (lowest set bit)
//   mask : one-hot mask of the selected bit, 0 when data is zero
//   idx  : position of the selected bit, 0 when data is zero
//   zero : high when data is all zeros
// ---------------------------------------------------------------------------
module mul_one_detect
  import mul_pkg::*;
#(
  parameter  int INPUT_WIDTH = 24,
  localparam int IDX_W       = $clog2(INPUT_WIDTH)
) (
  input  logic [INPUT_WIDTH-1:0] data,
  input  mode_e                  mode,
  output logic [INPUT_WIDTH-1:0] mask,
  output logic [IDX_W-1:0]       idx,
  output logic                   zero
);

  // Priority search: the scan runs towards the side that should win, so the
  // last matching bit seen is the one we keep. The mask is rebuilt from the
  // index so it is one-hot by construction.
  always_comb begin
    idx  = '0;
    zero = (data == '0);
    if (mode == MODE_LEAD) begin
      for (int i = 0; i < INPUT_WIDTH; i++) begin
        if (data[i]) idx = IDX_W'(i);
      end
    end else begin
      for (int i = INPUT_WIDTH - 1; i >= 0; i--) begin
        if (data[i]) idx = IDX_W'(i);
      end
    end
    mask = zero ? '0 : (INPUT_WIDTH'(1) << idx);
  end

endmodule

// File: rtl/mul_norm_pipe.sv
// ---------------------------------------------------------------------------
// mul_norm_pipe
// Finds the leading or trailing one of an operand, normalises the operand
// around it and passes the result through PIPE_STAGES valid/ready stages.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   in_valid  : input beat present
//   in_ready  : input beat accepted this cycle
//   in_data   : operand
//   in_mode   : 0 = leading one, 1 = trailing one
//   out_valid : result beat present
//   out_ready : downstream accepts the result
//   out_mask  : one-hot mask of the selected bit
//   out_idx   : position of the selected bit
//   out_zero  : operand was all zeros
//   out_norm  : operand shifted so the selected bit sits at MSB (leading)
//               or at bit 0 (trailing)
// ---------------------------------------------------------------------------
module mul_norm_pipe
  import mul_pkg::*;
#(
  parameter  int INPUT_WIDTH = 24,
  parameter  int PIPE_STAGES = 2,
  localparam int IDX_W       = $clog2(INPUT_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INPUT_WIDTH-1:0] in_data,
  input  logic                   in_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INPUT_WIDTH-1:0] out_mask,
  output logic [IDX_W-1:0]       out_idx,
  output logic                   out_zero,
  output logic [INPUT_WIDTH-1:0] out_norm
);

  mode_e                  scan_mode;
  logic [INPUT_WIDTH-1:0] det_mask;
  logic [IDX_W-1:0]       det_idx;
  logic                   det_zero;

  assign scan_mode = mode_e'(in_mode);

  mul_one_detect #(
    .INPUT_WIDTH(INPUT_WIDTH)
  ) u_detect (
    .data (in_data),
    .mode (scan_mode),
    .mask (det_mask),
    .idx  (det_idx),
    .zero (det_zero)
  );

  // Normalising shift ahead of stage 0. INPUT_WIDTH-1 always fits in IDX_W
  // bits, so the leading shift amount never wraps. A zero operand shifts to
  // zero in either direction, so no special case is needed.
  logic [IDX_W-1:0]       lead_shift;
  logic [INPUT_WIDTH-1:0] norm_value;
  mul_result_t            in_result;

  always_comb begin
    lead_shift = IDX_W'(INPUT_WIDTH - 1) - det_idx;
    if (scan_mode == MODE_LEAD) begin
      norm_value = in_data << lead_shift;
    end else begin
      norm_value = in_data >> det_idx;
    end
    in_result      = '0;
    in_result.mask = MAX_W'(det_mask);
    in_result.idx  = MAX_IDX_W'(det_idx);
    in_result.zero = det_zero;
    in_result.norm = MAX_W'(norm_value);
  end

  logic [PIPE_STAGES-1:0] stage_valid;
  logic [PIPE_STAGES-1:0] stage_ready;
  mul_result_t            stage_data [PIPE_STAGES];
  logic                   up_valid   [PIPE_STAGES];
  mul_result_t            up_data    [PIPE_STAGES];

  // Ready ripples backwards from the output: a stage can load if it is empty
  // or if the stage after it is moving. A local accumulator keeps the chain
  // free of self-referencing vector reads.
  always_comb begin
    logic downstream;
    downstream  = out_ready;
    stage_ready = '0;
    for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
      stage_ready[k] = !stage_valid[k] || downstream;
      downstream     = stage_ready[k];
    end
  end

  // Upstream view for every stage: stage 0 sees the combinational result,
  // later stages see the register in front of them.
  always_comb begin
    up_valid[0] = in_valid;
    up_data[0]  = in_result;
    for (int k = 1; k < PIPE_STAGES; k++) begin
      up_valid[k] = stage_valid[k-1];
      up_data[k]  = stage_data[k-1];
    end
  end

  // Stage registers. Reset wins over any handshake in the same cycle. The
  // payload only moves when the upstream actually carries a beat, so a
  // stalled or idle input never disturbs stored data.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_valid <= '0;
      for (int k = 0; k < PIPE_STAGES; k++) begin
        stage_data[k] <= '0;
      end
    end else begin
      for (int k = 0; k < PIPE_STAGES; k++) begin
        if (stage_ready[k]) begin
          stage_valid[k] <= up_valid[k];
          if (up_valid[k]) begin
            stage_data[k] <= up_data[k];
          end
        end
      end
    end
  end

  mul_result_t last_result;
  logic        unused_result_bits;

  assign last_result        = stage_data[PIPE_STAGES-1];
  assign unused_result_bits = ^last_result;
  assign in_ready           = stage_ready[0];
  assign out_valid          = stage_valid[PIPE_STAGES-1];

  // Outputs read as zero whenever no beat is presented, which also gives
  // all-zero outputs straight after reset.
  always_comb begin
    out_mask = '0;
    out_idx  = '0;
    out_zero = 1'b0;
    out_norm = '0;
    if (out_valid) begin
      out_mask = last_result.mask[INPUT_WIDTH-1:0];
      out_idx  = last_result.idx[IDX_W-1:0];
      out_zero = last_result.zero;
      out_norm = last_result.norm[INPUT_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_mul_norm_pipe.sv
// ---------------------------------------------------------------------------
// tb_mul_norm_pipe
// Scoreboard bench for mul_norm_pipe (INPUT_WIDTH=24, PIPE_STAGES=2).
// The driver pushes a reference result for every accepted beat; a monitor
// pops and compares whenever an output beat is taken.
// ---------------------------------------------------------------------------
module tb_mul_norm_pipe;

  localparam int W  = 24;
  localparam int S  = 2;
  localparam int IW = $clog2(W);

  typedef struct packed {
    logic [W-1:0]  mask;
    logic [IW-1:0] idx;
    logic          zero;
    logic [W-1:0]  norm;
  } exp_t;

  logic          clk       = 1'b0;
  logic          rst       = 1'b1;
  logic          in_valid  = 1'b0;
  logic          in_mode   = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  in_data   = '0;
  logic          in_ready;
  logic          out_valid;
  logic          out_zero;
  logic [W-1:0]  out_mask;
  logic [W-1:0]  out_norm;
  logic [IW-1:0] out_idx;

  int   checks    = 0;
  int   failures  = 0;
  int   acc_count = 0;
  int   got_count = 0;
  exp_t sb [$];

  mul_norm_pipe #(
    .INPUT_WIDTH(W),
    .PIPE_STAGES(S)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mask  (out_mask),
    .out_idx   (out_idx),
    .out_zero  (out_zero),
    .out_norm  (out_norm)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Reference result from plain arithmetic: the leading index is floor(log2),
  // the trailing index is the count of factors of two; normalising is a
  // multiply by a power of two, or just the odd part of the operand.
  function automatic exp_t refModel(input logic [W-1:0] d, input logic m);
    exp_t            e;
    longint unsigned v;
    longint unsigned t;
    int              p;
    e      = '0;
    e.zero = (d == '0);
    v      = 64'(d);
    p      = 0;
    if (d != '0) begin
      if (m == 1'b0) begin
        while (v > 1) begin
          v = v / 2;
          p++;
        end
        t      = 64'(d) * (64'd1 << (W - 1 - p));
        e.norm = t[W-1:0];
      end else begin
        while (v % 2 == 0) begin
          v = v / 2;
          p++;
        end
        e.norm = v[W-1:0];
      end
      t      = 64'd1 << p;
      e.mask = t[W-1:0];
      e.idx  = IW'(p);
    end
    return e;
  endfunction

  // One comparison: counted, and reported on mismatch.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs (called at posedge+1), record the expected
  // result if the beat is accepted at the coming edge, and return at the
  // next posedge+1.
  task automatic applyStimulus(input logic v, input logic [W-1:0] d, input logic m, input logic ordy);
    in_valid  = v;
    in_data   = d;
    in_mode   = m;
    out_ready = ordy;
    #1;
    if (v && in_ready && !rst) begin
      sb.push_back(refModel(d, m));
      acc_count++;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor on the falling edge: pop and compare every taken output beat,
  // and check that a stalled beat is still presented unchanged.
  exp_t mon_e;
  exp_t held;
  logic stall_seen = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      stall_seen = 1'b0;
    end else begin
      if (stall_seen) begin
        checkOutput("hold_valid", 64'(out_valid), 64'd1);
        checkOutput("hold_payload", 64'({out_mask, out_idx, out_zero, out_norm}),
                    64'({held.mask, held.idx, held.zero, held.norm}));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_output actual_mask=0x%0h required=none", out_mask);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("sb_mask", 64'(out_mask), 64'(mon_e.mask));
          checkOutput("sb_idx",  64'(out_idx),  64'(mon_e.idx));
          checkOutput("sb_zero", 64'(out_zero), 64'(mon_e.zero));
          checkOutput("sb_norm", 64'(out_norm), 64'(mon_e.norm));
          got_count++;
        end
      end
      stall_seen = out_valid && !out_ready;
      held.mask  = out_mask;
      held.idx   = out_idx;
      held.zero  = out_zero;
      held.norm  = out_norm;
    end
  end

  // Hard stop if the stimulus ever stalls completely.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed operands with hand-derived expectations.
  logic [W-1:0]  dir_data [5] = '{24'h000100, 24'h0A0000, 24'h000000, 24'h000000, 24'h800001};
  logic          dir_mode [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [IW-1:0] dir_idx  [5] = '{5'd8, 5'd17, 5'd0, 5'd0, 5'd23};
  logic [W-1:0]  dir_mask [5] = '{24'h000100, 24'h020000, 24'h000000, 24'h000000, 24'h800000};
  logic [W-1:0]  dir_norm [5] = '{24'h800000, 24'h000005, 24'h000000, 24'h000000, 24'h800001};
  logic          dir_zero [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  // Main sequence.
  initial begin
    exp_t         a_exp;
    logic [W-1:0] r;
    int           base_got;
    int           base_acc;
    int           guard;

    // Reset state.
    @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_outputs", 64'({out_mask, out_idx, out_zero, out_norm}), 64'd0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    rst = 1'b0;
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_out_valid_after", 64'(out_valid), 64'd0);

    // Directed results with exact two-cycle latency.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, dir_data[i], dir_mode[i], 1'b1);
      checkOutput($sformatf("dir%0d_early_valid", i), 64'(out_valid), 64'd0);
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      checkOutput($sformatf("dir%0d_valid", i), 64'(out_valid), 64'd1);
      checkOutput($sformatf("dir%0d_idx", i),   64'(out_idx),   64'(dir_idx[i]));
      checkOutput($sformatf("dir%0d_mask", i),  64'(out_mask),  64'(dir_mask[i]));
      checkOutput($sformatf("dir%0d_norm", i),  64'(out_norm),  64'(dir_norm[i]));
      checkOutput($sformatf("dir%0d_zero", i),  64'(out_zero),  64'(dir_zero[i]));
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);

    // Backpressure: A and B fill the pipe, C waits, then all drain in order.
    a_exp = refModel(24'h000F00, 1'b0);
    applyStimulus(1'b1, 24'h000F00, 1'b0, 1'b0);
    applyStimulus(1'b1, 24'h003000, 1'b1, 1'b0);
    checkOutput("bp_in_ready_full", 64'(in_ready), 64'd0);
    checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
    checkOutput("bp_head_mask", 64'(out_mask), 64'(a_exp.mask));
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 24'h0000C0, 1'b0, 1'b0);
      checkOutput($sformatf("bp_in_ready_hold%0d", i), 64'(in_ready), 64'd0);
    end
    checkOutput("bp_head_norm", 64'(out_norm), 64'(a_exp.norm));
    base_got = got_count;
    base_acc = acc_count;
    applyStimulus(1'b1, 24'h0000C0, 1'b0, 1'b1);
    checkOutput("bp_c_accepted", 64'(acc_count - base_acc), 64'd1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("bp_release_count", 64'(got_count - base_got), 64'd3);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);

    // Reset with two beats in flight; a same-cycle handshake must be dropped.
    applyStimulus(1'b1, 24'h123456, 1'b0, 1'b0);
    applyStimulus(1'b1, 24'h654320, 1'b1, 1'b0);
    rst = 1'b1;
    sb.delete();
    applyStimulus(1'b1, 24'h00FF00, 1'b0, 1'b1);
    rst = 1'b0;
    checkOutput("mid_rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("mid_rst_outputs", 64'({out_mask, out_idx, out_zero, out_norm}), 64'd0);
    checkOutput("mid_rst_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 24'hFFFFFF, 1'b1, 1'b1);
      checkOutput($sformatf("mid_rst_quiet%0d", i), 64'(out_valid), 64'd0);
    end

    // Full throughput: 20 back-to-back beats, 18 delivered after the fill.
    base_got = got_count;
    base_acc = acc_count;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, W'($urandom), 1'($urandom_range(0, 1)), 1'b1);
    end
    checkOutput("tput_accepted", 64'(acc_count - base_acc), 64'd20);
    checkOutput("tput_delivered", 64'(got_count - base_got), 64'd18);

    // Random traffic: 1000 accepted beats with 50% valid and 50% ready.
    base_acc = acc_count;
    guard    = 0;
    while ((acc_count - base_acc) < 1000 && guard < 20000) begin
      r = W'($urandom) >> $urandom_range(0, W - 1);
      if ($urandom_range(0, 19) == 0) r = '0;
      applyStimulus(1'($urandom_range(0, 1)), r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      guard++;
    end
    checkOutput("rand_accepted", 64'(acc_count - base_acc), 64'd1000);

    // Drain with a bounded wait.
    guard = 0;
    while (sb.size() != 0 && guard < 50) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      guard++;
    end
    checkOutput("drain_empty", 64'(sb.size()), 64'd0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
